// File: rtl/packet_buffer_pkg.sv
// Shared constants, index/length types and slot states for the packet buffer.
package packet_buffer_pkg;

  localparam int unsigned PB_DATA_W = 8;
  localparam int unsigned PB_DEPTH  = 16;
  localparam int unsigned PB_SLOTS  = 4;

  localparam int unsigned PB_SLOT_W = $clog2(PB_SLOTS);
  localparam int unsigned PB_IDX_W  = $clog2(PB_DEPTH);
  localparam int unsigned PB_LEN_W  = $clog2(PB_DEPTH + 1);

  typedef logic [PB_SLOT_W-1:0] slot_ptr_t;
  typedef logic [PB_IDX_W-1:0]  word_idx_t;
  typedef logic [PB_LEN_W-1:0]  len_t;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    WRITING = 2'd1,
    READY   = 2'd2
  } slot_state_e;

endpackage

// File: rtl/packet_buffer_ram.sv
// Slot memory: one synchronous write port, one registered read port that can be
// forced to zero for out-of-packet reads. Contents are not cleared by reset.
module packet_buffer_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic              i_rd_zero,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned WORDS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         r_rdata <= '0;
    else if (i_rd_zero) r_rdata <= '0;
    else                r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/packet_buffer_cntr.sv
// Packet FIFO of fixed-size slots: slot allocation, lengths and read/write pointers.
// Optional `level` output (READY slots awaiting the reader) under PACKET_BUFFER_LEVEL_EN.
module packet_buffer_cntr
  import packet_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = PB_DATA_W,
  parameter int unsigned DEPTH  = PB_DEPTH,
  parameter int unsigned SLOTS  = PB_SLOTS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_next,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_open,
  output logic [$clog2(DEPTH+1)-1:0] wr_len,
  output logic                       wr_full,
  input  logic                       rd_next,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] rd_len,
`ifdef PACKET_BUFFER_LEVEL_EN
  output logic [$clog2(SLOTS+1)-1:0] level,
`endif
  output logic [DATA_W-1:0]          rd_data
);

  localparam int unsigned SW = $clog2(SLOTS);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(SLOTS + 1);

  slot_state_e   r_state     [SLOTS];
  slot_state_e   w_state_nxt [SLOTS];
  logic [LW-1:0] r_len       [SLOTS];
  logic [LW-1:0] w_len_nxt   [SLOTS];

  logic [SW-1:0] r_alloc_ptr, w_alloc_nxt;
  logic [SW-1:0] r_sel_ptr,   w_sel_nxt;
  logic [SW-1:0] r_wr_slot,   w_wr_slot_nxt;
  logic [SW-1:0] r_rd_slot,   w_rd_slot_nxt;
  logic [OW-1:0] r_occ,       w_occ_nxt;
  logic [OW-1:0] r_pend,      w_pend_nxt;
  logic          r_wr_open,   w_wr_open_nxt;
  logic          r_rd_valid,  w_rd_valid_nxt;
  logic [LW-1:0] r_wr_len,    w_wr_len_nxt;
  logic [LW-1:0] r_rd_len,    w_rd_len_nxt;

  logic          w_wr_fire;
  logic          w_release;
  logic          w_can_alloc;
  logic          w_rd_zero;
  logic [LW-1:0] w_wr_end;

  assign w_wr_fire = wr_en && r_wr_open && !wr_next;
  assign w_release = rd_next && r_rd_valid;
  assign w_wr_end  = LW'(wr_idx) + LW'(1);
  // The slot released this edge is the one the allocator reaches next when full.
  assign w_can_alloc = (r_state[r_alloc_ptr] == FREE) ||
                       (w_release && (r_rd_slot == r_alloc_ptr));
  assign w_rd_zero = !r_rd_valid || (LW'(rd_idx) >= r_rd_len);

  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_alloc_nxt    = r_alloc_ptr;
    w_sel_nxt      = r_sel_ptr;
    w_wr_slot_nxt  = r_wr_slot;
    w_rd_slot_nxt  = r_rd_slot;
    w_occ_nxt      = r_occ;
    w_pend_nxt     = r_pend;
    w_wr_open_nxt  = r_wr_open;
    w_rd_valid_nxt = r_rd_valid;
    w_rd_len_nxt   = r_rd_len;
    w_wr_len_nxt   = '0;

    if (w_wr_fire && (w_wr_end > r_len[r_wr_slot]))
      w_len_nxt[r_wr_slot] = w_wr_end;

    if (w_release) begin
      w_state_nxt[r_rd_slot] = FREE;
      w_occ_nxt              = w_occ_nxt - OW'(1);
    end

    // Reader picks from slots pending before this edge; a WRITING pick is force-closed.
    if (rd_next) begin
      if (r_pend != '0) begin
        w_rd_valid_nxt = 1'b1;
        w_rd_slot_nxt  = r_sel_ptr;
        w_rd_len_nxt   = w_len_nxt[r_sel_ptr];
        w_sel_nxt      = r_sel_ptr + SW'(1);
        w_pend_nxt     = w_pend_nxt - OW'(1);
        if (r_state[r_sel_ptr] == WRITING) begin
          w_state_nxt[r_sel_ptr] = READY;
          w_wr_open_nxt          = 1'b0;
        end
      end else begin
        w_rd_valid_nxt = 1'b0;
        w_rd_len_nxt   = '0;
      end
    end

    if (wr_next) begin
      if (r_wr_open) w_state_nxt[r_wr_slot] = READY;
      w_wr_open_nxt = 1'b0;
      if (w_can_alloc) begin
        w_state_nxt[r_alloc_ptr] = WRITING;
        w_len_nxt[r_alloc_ptr]   = '0;
        w_wr_slot_nxt            = r_alloc_ptr;
        w_alloc_nxt              = r_alloc_ptr + SW'(1);
        w_pend_nxt               = w_pend_nxt + OW'(1);
        w_occ_nxt                = w_occ_nxt + OW'(1);
        w_wr_open_nxt            = 1'b1;
      end
    end

    if (w_wr_open_nxt) w_wr_len_nxt = w_len_nxt[w_wr_slot_nxt];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SLOTS; s++) begin
        r_state[s] <= FREE;
        r_len[s]   <= '0;
      end
      r_alloc_ptr <= '0;
      r_sel_ptr   <= '0;
      r_wr_slot   <= '0;
      r_rd_slot   <= '0;
      r_occ       <= '0;
      r_pend      <= '0;
      r_wr_open   <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_wr_len    <= '0;
      r_rd_len    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_alloc_ptr <= w_alloc_nxt;
      r_sel_ptr   <= w_sel_nxt;
      r_wr_slot   <= w_wr_slot_nxt;
      r_rd_slot   <= w_rd_slot_nxt;
      r_occ       <= w_occ_nxt;
      r_pend      <= w_pend_nxt;
      r_wr_open   <= w_wr_open_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      r_wr_len    <= w_wr_len_nxt;
      r_rd_len    <= w_rd_len_nxt;
    end
  end

`ifdef PACKET_BUFFER_LEVEL_EN
  // The open write slot is always among the pending ones, so READY-pending = pending - open.
  logic [OW-1:0] r_level;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_level <= '0;
    else        r_level <= w_pend_nxt - OW'(w_wr_open_nxt);
  end

  assign level = r_level;
`endif

  assign wr_open  = r_wr_open;
  assign wr_len   = r_wr_len;
  assign wr_full  = (r_occ == OW'(SLOTS));
  assign rd_valid = r_rd_valid;
  assign rd_len   = r_rd_len;

  packet_buffer_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (SW + IW)
  ) u_ram (
    .clock     (clock),
    .reset     (reset),
    .i_we      (w_wr_fire),
    .i_waddr   ({r_wr_slot, wr_idx}),
    .i_wdata   (wr_data),
    .i_raddr   ({r_rd_slot, rd_idx}),
    .i_rd_zero (w_rd_zero),
    .o_rdata   (rd_data)
  );

endmodule

// File: tb/tb_packet_buffer_cntr.sv
// Bench for packet_buffer_cntr: directed vector table, reset-mid-write sequence,
// then random traffic against a packet-queue reference model.
module tb_packet_buffer_cntr;
  import packet_buffer_pkg::*;

  localparam int unsigned DW = PB_DATA_W;
  localparam int unsigned DP = PB_DEPTH;
  localparam int unsigned NS = PB_SLOTS;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            wr_next = 1'b0, wr_en = 1'b0, rd_next = 1'b0;
  word_idx_t       wr_idx = '0, rd_idx = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            wr_open, wr_full, rd_valid;
  len_t            wr_len, rd_len;
  logic [DW-1:0]   rd_data;
`ifdef PACKET_BUFFER_LEVEL_EN
  logic [$clog2(NS+1)-1:0] level;
`endif

  packet_buffer_cntr dut (
    .clock   (clock),
    .reset   (reset),
    .wr_next (wr_next),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_open (wr_open),
    .wr_len  (wr_len),
    .wr_full (wr_full),
    .rd_next (rd_next),
    .rd_idx  (rd_idx),
    .rd_valid(rd_valid),
    .rd_len  (rd_len),
`ifdef PACKET_BUFFER_LEVEL_EN
    .level   (level),
`endif
    .rd_data (rd_data)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: pending packets in allocation order plus the packet being read.
  typedef struct packed {
    len_t               len;
    logic [DP-1:0]      mask;
    logic [DP*DW-1:0]   data;
  } pkt_t;

  pkt_t          m_q[$];
  pkt_t          m_cur;
  bit            m_rv, m_wo;
  bit            m_dknown;
  logic [DW-1:0] m_data;

  task automatic model_reset();
    m_q.delete();
    m_cur = '0;
    m_rv  = 1'b0;
    m_wo  = 1'b0;
  endtask

  task automatic model_step(input int wn, input int we, input int widx, input int wd,
                            input int rn, input int ridx);
    pkt_t t;
    int   pend, occ;
    bit   rel;
    m_dknown = 1'b1;
    m_data   = '0;
    if (m_rv && ridx < int'(m_cur.len)) begin
      if (m_cur.mask[ridx]) m_data = m_cur.data[ridx*DW +: DW];
      else                  m_dknown = 1'b0;
    end
    pend = m_q.size();
    occ  = pend + int'(m_rv);
    rel  = (rn != 0) && m_rv;
    if (we != 0 && m_wo && wn == 0) begin
      t = m_q[pend-1];
      t.data[widx*DW +: DW] = DW'(wd);
      t.mask[widx] = 1'b1;
      if (widx + 1 > int'(t.len)) t.len = len_t'(widx + 1);
      m_q[pend-1] = t;
    end
    if (rn != 0) begin
      if (pend > 0) begin
        m_cur = m_q.pop_front();
        m_rv  = 1'b1;
        if (m_wo && pend == 1) m_wo = 1'b0;
      end else begin
        m_rv = 1'b0;
      end
    end
    if (wn != 0) begin
      m_wo = 1'b0;
      if (occ < int'(NS) || rel) begin
        m_q.push_back('0);
        m_wo = 1'b1;
      end
    end
  endtask

  task automatic step(input int wn, input int we, input int widx, input int wd,
                      input int rn, input int ridx);
    wr_next = 1'(wn);
    wr_en   = 1'(we);
    wr_idx  = word_idx_t'(widx);
    wr_data = DW'(wd);
    rd_next = 1'(rn);
    rd_idx  = word_idx_t'(ridx);
    model_step(wn, we, widx, wd, rn, ridx);
    @(posedge clock);
    #1;
  endtask

  typedef struct packed {
    logic          wn, we;
    word_idx_t     widx;
    logic [DW-1:0] wd;
    logic          rn;
    word_idx_t     ridx;
    logic          e_open;
    len_t          e_wlen;
    logic          e_full, e_rv;
    len_t          e_rlen;
    logic [DW-1:0] e_data;
  } vec_t;

  function automatic vec_t mk(input int wn, we, widx, wd, rn, ridx,
                              input int eo, ewl, ef, erv, erl, ed);
    vec_t v;
    v.wn = 1'(wn);  v.we = 1'(we);  v.widx = word_idx_t'(widx);  v.wd = DW'(wd);
    v.rn = 1'(rn);  v.ridx = word_idx_t'(ridx);
    v.e_open = 1'(eo);  v.e_wlen = len_t'(ewl);  v.e_full = 1'(ef);
    v.e_rv = 1'(erv);   v.e_rlen = len_t'(erl);  v.e_data = DW'(ed);
    return v;
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, " wr_open"},  32'(wr_open),  32'(m_wo));
    chk({tag, " wr_len"},   32'(wr_len),   m_wo ? 32'(m_q[m_q.size()-1].len) : 32'd0);
    chk({tag, " wr_full"},  32'(wr_full),  32'((m_q.size() + int'(m_rv)) == int'(NS)));
    chk({tag, " rd_valid"}, 32'(rd_valid), 32'(m_rv));
    chk({tag, " rd_len"},   32'(rd_len),   m_rv ? 32'(m_cur.len) : 32'd0);
    if (m_dknown) chk({tag, " rd_data"}, 32'(rd_data), 32'(m_data));
`ifdef PACKET_BUFFER_LEVEL_EN
    chk({tag, " level"}, 32'(level), 32'(m_q.size() - int'(m_wo)));
`endif
  endtask

  vec_t tv[$];

  initial begin
    vec_t v;
    // Directed scenario: two packets, reads, forced close, full, dropped write.
    tv.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0,0));
    for (int i = 0; i < 8; i++) tv.push_back(mk(0,1,i,100+i,0,0, 1,i+1,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0, 1,0,0,0,0,0));
    for (int i = 0; i < 4; i++) tv.push_back(mk(0,1,i,200+i,0,0, 1,i+1,0,0,0,0));
    tv.push_back(mk(0,0,0,0,1,0, 1,4,0,1,8,0));
    for (int i = 0; i < 8; i++) tv.push_back(mk(0,0,0,0,0,i, 1,4,0,1,8,100+i));
    tv.push_back(mk(0,0,0,0,0,8, 1,4,0,1,8,0));
    tv.push_back(mk(0,0,0,0,1,0, 0,0,0,1,4,100));
    for (int i = 0; i < 4; i++) tv.push_back(mk(0,0,0,0,0,i, 0,0,0,1,4,200+i));
    tv.push_back(mk(0,0,0,0,0,4, 0,0,0,1,4,0));
    tv.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,200));
    tv.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
    for (int i = 0; i < 4; i++) tv.push_back(mk(1,0,0,0,0,0, 1,0,(i==3)?1:0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0, 0,0,1,0,0,0));
    tv.push_back(mk(0,0,0,0,1,0, 0,0,1,1,0,0));
    tv.push_back(mk(1,0,0,0,1,0, 1,0,1,1,0,0));
    tv.push_back(mk(1,1,5,77,0,0, 0,0,1,1,0,0));
    tv.push_back(mk(0,0,0,0,1,0, 0,0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,1,0, 0,0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,1,0, 0,0,0,1,0,0));
    tv.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,0));

    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("reset wr_open", 32'(wr_open), 0);
    chk("reset wr_len", 32'(wr_len), 0);
    chk("reset wr_full", 32'(wr_full), 0);
    chk("reset rd_valid", 32'(rd_valid), 0);
    chk("reset rd_len", 32'(rd_len), 0);
    chk("reset rd_data", 32'(rd_data), 0);
`ifdef PACKET_BUFFER_LEVEL_EN
    chk("reset level", 32'(level), 0);
`endif
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    for (int k = 0; k < tv.size(); k++) begin
      v = tv[k];
      step(int'(v.wn), int'(v.we), int'(v.widx), int'(v.wd), int'(v.rn), int'(v.ridx));
      chk($sformatf("vec%0d wr_open", k),  32'(wr_open),  32'(v.e_open));
      chk($sformatf("vec%0d wr_len", k),   32'(wr_len),   32'(v.e_wlen));
      chk($sformatf("vec%0d wr_full", k),  32'(wr_full),  32'(v.e_full));
      chk($sformatf("vec%0d rd_valid", k), 32'(rd_valid), 32'(v.e_rv));
      chk($sformatf("vec%0d rd_len", k),   32'(rd_len),   32'(v.e_rlen));
      chk($sformatf("vec%0d rd_data", k),  32'(rd_data),  32'(v.e_data));
    end

    // Asynchronous reset in the middle of filling a packet.
    step(1,0,0,0,0,0);
    for (int i = 0; i < 3; i++) step(0,1,i,50+i,0,0);
    chk("midwr wr_len", 32'(wr_len), 3);
    step(0,0,0,0,1,0);
    chk("midwr rd_valid", 32'(rd_valid), 1);
    wr_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst wr_open", 32'(wr_open), 0);
    chk("arst wr_len", 32'(wr_len), 0);
    chk("arst wr_full", 32'(wr_full), 0);
    chk("arst rd_valid", 32'(rd_valid), 0);
    chk("arst rd_len", 32'(rd_len), 0);
    chk("arst rd_data", 32'(rd_data), 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    step(0,0,0,0,1,0);
    chk("post-reset rd_valid", 32'(rd_valid), 0);
    chk("post-reset rd_len", 32'(rd_len), 0);

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      int wn, we, rn;
      wn = ($urandom_range(0, 9) == 0) ? 1 : 0;
      rn = ($urandom_range(0, 9) == 0) ? 1 : 0;
      we = ($urandom_range(0, 9) < 6) ? 1 : 0;
      step(wn, we, int'($urandom_range(0, DP-1)), int'($urandom_range(0, 255)),
           rn, int'($urandom_range(0, DP-1)));
      chk_model($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
